// File: rtl/mips_cpu_load_store_unit.sv
// mips_cpu_load_store_unit
//
// Purpose: executes one load or store at a time against a word-wide data
// port that has no byte enables. Sub-word loads are handled by lane
// selection and extension. Sub-word stores use a read-modify-write pair
// of accesses. Misaligned and illegal requests complete without touching
// memory.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset to IDLE
//   req, op, addr,    request strobe (sampled in IDLE only), operation,
//   wdata             byte address, rt value (store data / LWL-LWR source)
//   busy              high whenever the unit is not IDLE
//   done, err         one-cycle completion pulse; err qualifies done
//   rdata             load result, held until the next load completes
//   data_address      word index {2'b00, addr[31:2]} of the latched address
//   data_read         memory read strobe (read data is combinational)
//   data_write        memory write strobe (write happens on next rising edge)
//   data_writedata    word to write, 0 whenever data_write is low
//   data_readdata     memory read data
//
// Handshake: a request is accepted on a rising edge where the unit is IDLE
// and req=1. There is no ready output; busy=0 means the next edge can
// accept. The response is the done pulse. req seen while busy is dropped,
// not queued.

module mips_cpu_load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LWL = 4'd5;
    localparam logic [3:0] OP_LWR = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_RMW_WR = 3'd3,
        S_WR     = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] merge_q, merge_d;
    logic        err_q, err_d;

    // Classification of the live request; only used on the accept edge.
    logic in_is_load;
    logic in_is_sub_store;
    logic in_bad;

    always_comb begin
        in_is_load      = (op <= OP_LWR);
        in_is_sub_store = (op == OP_SB) || (op == OP_SH);
        in_bad          = 1'b0;
        if (!(in_is_load || in_is_sub_store || (op == OP_SW))) begin
            in_bad = 1'b1;
        end
        if (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && addr[0]) begin
            in_bad = 1'b1;
        end
        if (((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00)) begin
            in_bad = 1'b1;
        end
    end

    // Load result from the memory word and the latched rt value.
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_result;

    always_comb begin
        sel_byte = data_readdata[7:0];
        case (addr_q[1:0])
            2'd0: sel_byte = data_readdata[7:0];
            2'd1: sel_byte = data_readdata[15:8];
            2'd2: sel_byte = data_readdata[23:16];
            2'd3: sel_byte = data_readdata[31:24];
            default: sel_byte = data_readdata[7:0];
        endcase
        sel_half = addr_q[1] ? data_readdata[31:16] : data_readdata[15:0];

        load_result = data_readdata;
        case (op_q)
            OP_LB:  load_result = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU: load_result = {24'd0, sel_byte};
            OP_LH:  load_result = {{16{sel_half[15]}}, sel_half};
            OP_LHU: load_result = {16'd0, sel_half};
            OP_LW:  load_result = data_readdata;
            // LWL fills the upper bytes of rt with the low bytes of memory.
            OP_LWL: begin
                case (addr_q[1:0])
                    2'd0: load_result = {data_readdata[7:0],  wdata_q[23:0]};
                    2'd1: load_result = {data_readdata[15:0], wdata_q[15:0]};
                    2'd2: load_result = {data_readdata[23:0], wdata_q[7:0]};
                    default: load_result = data_readdata;
                endcase
            end
            // LWR fills the lower bytes of rt with the high bytes of memory.
            OP_LWR: begin
                case (addr_q[1:0])
                    2'd1: load_result = {wdata_q[31:24], data_readdata[31:8]};
                    2'd2: load_result = {wdata_q[31:16], data_readdata[31:16]};
                    2'd3: load_result = {wdata_q[31:8],  data_readdata[31:24]};
                    default: load_result = data_readdata;
                endcase
            end
            default: load_result = data_readdata;
        endcase
    end

    // Sub-word store merge: the new lane(s) over the word read in RMW_RD.
    logic [31:0] merged_word;

    always_comb begin
        merged_word = data_readdata;
        if (op_q == OP_SB) begin
            case (addr_q[1:0])
                2'd0: merged_word[7:0]   = wdata_q[7:0];
                2'd1: merged_word[15:8]  = wdata_q[7:0];
                2'd2: merged_word[23:16] = wdata_q[7:0];
                2'd3: merged_word[31:24] = wdata_q[7:0];
                default: merged_word = data_readdata;
            endcase
        end else begin
            if (addr_q[1]) begin
                merged_word[31:16] = wdata_q[15:0];
            end else begin
                merged_word[15:0] = wdata_q[15:0];
            end
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        merge_d = merge_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_d    = op;
                    addr_d  = addr;
                    wdata_d = wdata;
                    err_d   = in_bad;
                    if (in_bad) begin
                        state_d = S_DONE;
                    end else if (in_is_load) begin
                        state_d = S_LOAD;
                    end else if (in_is_sub_store) begin
                        state_d = S_RMW_RD;
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_LOAD: begin
                rdata_d = load_result;
                state_d = S_DONE;
            end
            S_RMW_RD: begin
                merge_d = merged_word;
                state_d = S_RMW_WR;
            end
            S_RMW_WR: state_d = S_DONE;
            S_WR:     state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            merge_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
            err_q   <= err_d;
        end
    end

    // Moore outputs: decoded from state and latched registers only, so an
    // asynchronous reset removes every strobe immediately.
    always_comb begin
        busy           = (state_q != S_IDLE);
        done           = (state_q == S_DONE);
        err            = (state_q == S_DONE) && err_q;
        rdata          = rdata_q;
        data_address   = {2'b00, addr_q[31:2]};
        data_read      = (state_q == S_LOAD) || (state_q == S_RMW_RD);
        data_write     = (state_q == S_RMW_WR) || (state_q == S_WR);
        data_writedata = 32'd0;
        if (state_q == S_RMW_WR) begin
            data_writedata = merge_q;
        end else if (state_q == S_WR) begin
            data_writedata = wdata_q;
        end
    end

endmodule

// File: tb/tb_mips_cpu_load_store_unit.sv
// Bench for mips_cpu_load_store_unit: directed scenarios plus randomized
// traffic against a word-array reference model, with a queue scoreboard.

module tb_mips_cpu_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    mips_cpu_load_store_unit dut (
        .clk            (clk),
        .reset          (rst),
        .req            (req),
        .op             (op),
        .addr           (addr),
        .wdata          (wdata),
        .busy           (busy),
        .done           (done),
        .rdata          (rdata),
        .err            (err),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata)
    );

    // ---------------- clock / reset / memory ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem [0:255];
    assign data_readdata = mem[data_address[7:0]];
    always @(posedge clk) begin
        if (data_write) mem[data_address[7:0]] <= data_writedata;
    end

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];          // {err, rdata}
    int          when_q[$];         // cycle in which done is expected
    int          busy_start = 0;
    int          busy_end   = 0;
    int          rd_cyc     = -1;
    int          wr_cyc     = -1;
    logic [31:0] exp_wd     = 32'd0;
    logic [31:0] cur_word   = 32'd0;
    logic [31:0] ref_mem [0:15];    // words 0x100..0x10F
    logic [31:0] ref_rdata  = 32'd0;
    bit          hold_mode  = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Computes the architectural effect of one request on ref_mem/ref_rdata.
    task automatic predict(input int o_code, input logic [31:0] a, input logic [31:0] wd,
                           output bit e, output logic [31:0] res, output int lat,
                           output int rd_k, output int wr_k, output logic [31:0] wword);
        int          o;
        int          w;
        logic [31:0] m;
        logic [31:0] v;
        logic [31:0] mask;
        o     = int'(a[1:0]);
        w     = int'(a >> 2) - 'h100;
        m     = ref_mem[w];
        e     = 1'b0;
        lat   = 2;
        rd_k  = -1;
        wr_k  = -1;
        wword = 32'd0;
        if (!((o_code >= 0 && o_code <= 6) || (o_code >= 8 && o_code <= 10))) e = 1'b1;
        if ((o_code == 2 || o_code == 3 || o_code == 9) && (a % 2 != 0)) e = 1'b1;
        if ((o_code == 4 || o_code == 10) && (a % 4 != 0)) e = 1'b1;
        if (e) begin
            lat = 1;
        end else if (o_code <= 6) begin
            rd_k = 1;
            case (o_code)
                0, 1: begin
                    v = (m >> (8 * o)) & 32'hFF;
                    if (o_code == 0 && v >= 32'd128) v = v | 32'hFFFFFF00;
                end
                2, 3: begin
                    v = (m >> (16 * (o / 2))) & 32'hFFFF;
                    if (o_code == 2 && v >= 32'h8000) v = v | 32'hFFFF0000;
                end
                4: v = m;
                5: v = (o == 3) ? m : ((m << (8 * (3 - o))) | (wd & ((32'd1 << (8 * (3 - o))) - 32'd1)));
                default: v = (o == 0) ? m : ((m >> (8 * o)) | (wd & ~(32'hFFFFFFFF >> (8 * o))));
            endcase
            ref_rdata = v;
        end else if (o_code == 10) begin
            wr_k       = 1;
            wword      = wd;
            ref_mem[w] = wd;
        end else begin
            rd_k = 1;
            wr_k = 2;
            lat  = 3;
            if (o_code == 8) begin
                mask  = 32'hFF << (8 * o);
                wword = (m & ~mask) | ((wd & 32'hFF) << (8 * o));
            end else begin
                mask  = 32'hFFFF << (16 * (o / 2));
                wword = (m & ~mask) | ((wd & 32'hFFFF) << (16 * (o / 2)));
            end
            ref_mem[w] = wword;
        end
        res = ref_rdata;
    endtask

    // ---------------- driver ----------------
    task automatic issue(input int o_code, input logic [31:0] a, input logic [31:0] wd);
        int          guard;
        bit          e;
        logic [31:0] res;
        logic [31:0] ww;
        int          lat;
        int          rk;
        int          wk;
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (guard >= 20) begin
            n_fail++;
            $display("FAIL idle_timeout: busy stuck high (cycle %0d)", cyc);
        end
        req   = 1'b1;
        op    = 4'(o_code);
        addr  = a;
        wdata = wd;
        predict(o_code, a, wd, e, res, lat, rk, wk, ww);
        exp_q.push_back({e, res});
        when_q.push_back(cyc + lat);
        busy_start = cyc;
        busy_end   = cyc + lat;
        rd_cyc     = (rk < 0) ? -1 : cyc + rk;
        wr_cyc     = (wk < 0) ? -1 : cyc + wk;
        exp_wd     = ww;
        cur_word   = {2'b00, a[31:2]};
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            // While busy, scramble the inputs: the unit must ignore them.
            if (!hold_mode) begin
                req   = 1'($urandom_range(0, 1));
                op    = 4'($urandom);
                addr  = $urandom;
                wdata = $urandom;
            end
        end
        @(negedge clk);
        if (!hold_mode) req = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [32:0] e;
        int          w;
        if (!rst) begin
            check32("busy", 32'(busy), 32'(cyc > busy_start && cyc <= busy_end));
            check32("data_read", 32'(data_read), 32'(cyc == rd_cyc));
            check32("data_write", 32'(data_write), 32'(cyc == wr_cyc));
            check32("rd_wr_exclusive", 32'(data_read && data_write), 32'd0);
            check32("data_writedata", data_writedata, (cyc == wr_cyc) ? exp_wd : 32'd0);
            if (data_read || data_write) check32("data_address", data_address, cur_word);
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    w = when_q.pop_front();
                    check32("done_cycle", cyc, w);
                    check32("err", 32'(err), 32'(e[32]));
                    check32("rdata", rdata, e[31:0]);
                end
            end else begin
                check32("err_without_done", 32'(err), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] wd;
        int          guard;
        int          o_code;
        int          pick;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h8899AABB;
        for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
        rst   = 1'b1;
        req   = 1'b0;
        op    = 4'd0;
        addr  = 32'd0;
        wdata = 32'd0;

        // Reset values.
        @(negedge clk);
        check32("rst_busy", 32'(busy), 32'd0);
        check32("rst_done", 32'(done), 32'd0);
        check32("rst_err", 32'(err), 32'd0);
        check32("rst_rd", 32'(data_read), 32'd0);
        check32("rst_wr", 32'(data_write), 32'd0);
        check32("rst_rdata", rdata, 32'd0);
        check32("rst_addr", data_address, 32'd0);
        check32("rst_wdata", data_writedata, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Byte loads, errors, LWL/LWR, read-modify-write store.
        issue(0, 32'h401, $urandom);
        issue(1, 32'h401, $urandom);
        issue(2, 32'h403, $urandom);
        issue(10, 32'h402, $urandom);
        issue(7, 32'h400, $urandom);
        issue(5, 32'h401, 32'h11223344);
        issue(6, 32'h401, 32'h11223344);
        issue(5, 32'h403, 32'h11223344);
        issue(6, 32'h400, 32'h11223344);
        issue(8, 32'h402, 32'h12345677);
        issue(4, 32'h400, $urandom);
        issue(10, 32'h400, 32'h8899AABB);

        // Asynchronous reset while an SH is in its write cycle.
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        wd         = $urandom;
        req        = 1'b1;
        op         = 4'd9;
        addr       = 32'h402;
        wdata      = wd;
        busy_start = cyc;
        busy_end   = cyc + 3;
        rd_cyc     = cyc + 1;
        wr_cyc     = cyc + 2;
        exp_wd     = (ref_mem[0] & 32'h0000FFFF) | (wd << 16);
        cur_word   = 32'h100;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check32("reset_drops_write", 32'(data_write), 32'd0);
        check32("reset_drops_busy", 32'(busy), 32'd0);
        check32("reset_drops_read", 32'(data_read), 32'd0);
        busy_end  = 0;
        rd_cyc    = -1;
        wr_cyc    = -1;
        ref_rdata = 32'd0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check32("aborted_write_mem", mem[0], ref_mem[0]);

        // req held high: accepts at minimum spacing.
        hold_mode = 1'b1;
        repeat (6) issue(4, 32'h400, $urandom);
        hold_mode = 1'b0;

        // Randomized traffic.
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            pick = $urandom_range(0, 9);
            if (pick < 8) begin
                o_code = (pick < 5) ? $urandom_range(0, 6) : $urandom_range(8, 10);
            end else begin
                o_code = $urandom_range(0, 15);
            end
            issue(o_code, 32'h400 + $urandom_range(0, 63), $urandom);
        end
        req = 1'b0;

        // Drain and final memory comparison.
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check32("pending_responses", exp_q.size(), 32'd0);
        for (int i = 0; i < 16; i++) check32("final_mem", mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_cpu_load_store_unit.md
# mips_cpu_load_store_unit

Load/store unit between the CPU datapath and the Harvard data port of `mips_cpu_memory`. It takes one load or store request at a time and turns it into word-wide memory accesses. That covers byte-lane extraction, sign/zero extension, LWL/LWR merging, and read-modify-write for sub-word stores, since the data port has no byte enables. It checks alignment and guarantees `data_read` and `data_write` are never asserted together.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; returns block to IDLE immediately.
- `req`  in  1  request strobe; sampled only in IDLE.
- `op`  in  4  operation:
  - 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR
  - 8 SB, 9 SH, 10 SW
  - all other codes are illegal.
- `addr`  in  32  byte address.
- `wdata`  in  32  rt value: store data, or merge source for LWL/LWR.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  load result; valid while `done`=1 and held until next completion.
- `err`  out  1  valid with `done`; 1 = misaligned or illegal op, no memory access made.
- `data_address`  out  32  word index to memory, `{2'b00, addr[31:2]}`.
- `data_read`  out  1  memory read strobe; memory read data is combinational.
- `data_write`  out  1  memory write strobe; memory writes on the next rising edge.
- `data_writedata`  out  32  word to write; 0 when `data_write`=0.
- `data_readdata`  in  32  memory read data.

## Operation
- Little-endian byte lanes: lane k = bits [8k+7:8k], k = `addr[1:0]`.
- On accept (IDLE and `req`=1 at an edge), latch `op`, `addr` and `wdata`. Latched values drive all later cycles.
- Error check at accept:
  - LH/LHU/SH with `addr[0]`=1 → error.
  - LW/SW with `addr[1:0]`≠0 → error.
  - Illegal `op` → error.
  - Error path: → DONE with `err`=1, no memory access, `rdata` unchanged.
- Load results, from memory word M and latched rt R, o = `addr[1:0]`:
  - LB/LBU: lane o, sign- or zero-extended.
  - LH/LHU: halfword at `addr[1]`, sign- or zero-extended.
  - LW: M.
  - LWL: {M[8o+7:0], R[8(3−o)−1:0]}; o=3 gives M.
  - LWR: {R[31:8(4−o)], M[31:8o]}; o=0 gives M.
- Stores:
  - SW: write `wdata` directly.
  - SB: replace lane o of the read word with `wdata[7:0]`.
  - SH: replace halfword `addr[1]` of the read word with `wdata[15:0]`.
  - SB/SH are read-modify-write; all other lanes are preserved.
- States and memory strobes:
  - IDLE: no strobes.
  - LOAD: `data_read`=1; result captured into `rdata` at cycle end.
  - RMW_RD: `data_read`=1; word captured into a merge register.
  - RMW_WR: `data_write`=1, `data_read`=0, `data_writedata` = merged word.
  - WR: `data_write`=1, `data_writedata` = `wdata`.
  - DONE: `done`=1, no strobes.
- State transitions:
  - IDLE → LOAD (loads), RMW_RD (SB/SH), WR (SW), DONE (error).
  - LOAD → DONE.
  - RMW_RD → RMW_WR → DONE.
  - WR → DONE.
  - DONE → IDLE unconditionally.
- `req` outside IDLE (including DONE) is ignored and not queued.
- Strobes and `data_address` are decoded from state and latched registers only (Moore), never from live inputs.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, `data_read`, `data_write` = 0; `rdata`, `data_address`, `data_writedata` = 0.
- Take accept edge = E0.
- Loads: `data_read` high in cycle E0→E1; `done` high in cycle E1→E2. Accept-to-done latency 2.
- SW: `data_write` in cycle 1, `done` in cycle 2.
- SB/SH: read in cycle 1, write in cycle 2, `done` in cycle 3.
- Error: `done`=1, `err`=1 in cycle 1.
- Next `req` is accepted at the edge ending DONE+1, i.e. once back in IDLE. Minimum request spacing is latency+1 cycles.
- `err`=0 on every non-error completion.
- Reset mid-operation: all strobes drop combinationally on assertion.
  - A write is aborted unless its rising edge had already occurred.
  - A pending `done` is lost.

## Test plan
Memory word index 0x100 (byte address 0x400) preloaded with 0x8899AABB.
1. LB, `addr`=0x401 → `data_read` cycle 1 with `data_address`=0x100; `done` cycle 2; `rdata`=0xFFFFFFAA, `err`=0. Repeat with LBU → `rdata`=0x000000AA.
2. SB, `addr`=0x402, `wdata`=0x12345677 → read cycle 1, write cycle 2 with `data_writedata`=0x8877AABB, `done` cycle 3; a following LW of 0x400 returns 0x8877AABB.
3. LH at 0x403, SW at 0x402, and `op`=7 each → `done`=1, `err`=1 in cycle 1; `data_read` and `data_write` stay 0; `rdata` unchanged.
4. `wdata`=0x11223344:
   - LWL at 0x401 → `rdata`=0xAABB3344.
   - LWR at 0x401 → `rdata`=0x118899AA.
   - LWL at 0x403 and LWR at 0x400 → 0x8899AABB.
5. Assert `reset` asynchronously mid-cycle during RMW_WR of an SH → `data_write` and `busy` drop immediately; memory still reads 0x8899AABB; no `done`.
6. Hold `req`=1 continuously with LW at 0x400 → accepts every 3 cycles; each `done` has `rdata`=0x8899AABB; `data_read` and `data_write` are never high together.
